seg7_mux_drv: RTL and testbench
===============================

Name: seg7_mux_drv

Overview:
Parametrised multiplexed driver for a bank of DIGITS common-anode 7-segment digits. It is the time-multiplexed successor of the team's single-digit hex decoder. It adds:
- a refresh scan with per-digit slots
- frame-synchronous (tear-free) value loading
- display blanking
- leading-zero suppression
- 16-level PWM brightness
It sits between the user-logic value registers and the board's segment and anode pins.

Parameters:
DIGITS, 4, number of digits scanned (1..8).
PHASE_LEN, 3125, clock cycles per brightness phase. One digit slot = 16*PHASE_LEN cycles (1 ms at 50 MHz).

Ports:
CLK  in  1  system clock, all logic on rising edge
RST_N  in  1  synchronous reset, active low
EN  in  1  1 = display on, 0 = all digits blanked
LZ_SUP  in  1  1 = suppress leading zeros
BRIGHT  in  4  duty level 0..15; lit phases per slot = BRIGHT+1
LOAD  in  1  one-cycle strobe that captures BIN and DP_IN
BIN  in  4*DIGITS  hex nibbles; BIN[3:0] = digit 0 (least significant, rightmost)
DP_IN  in  DIGITS  decimal point per digit, 1 = on
SEG  out  7  segments {g,f,e,d,c,b,a}, active low
DP_OUT  out  1  decimal point, active low
AN  out  DIGITS  digit enables, active low; AN[i] = digit i
FRAME  out  1  one-cycle pulse at the start of each scan frame

Behaviour:
- Reset (RST_N=0 at a clock edge), all synchronous:
  - AN all 1, SEG 7'h7F, DP_OUT 1, FRAME 0.
  - Display and pending registers 0; pending-valid flag 0.
  - Phase sub-counter, phase counter and digit index all 0.
  - Reset mid-frame restarts the scan at digit 0, phase 0.
- Counters:
  - Sub-counter runs 0..PHASE_LEN-1; at wrap the phase counter advances (0..15).
  - At phase wrap, digit index DIG advances 0..DIGITS-1, then wraps to 0.
  - The counters run regardless of EN, LZ_SUP and LOAD.
- Frame boundary: the cycle where DIG wraps DIGITS-1 -> 0.
  - FRAME pulses high for 1 cycle, aligned with the first cycle of digit 0's slot on AN.
  - With DIGITS=1, FRAME fires every slot.
- Loading:
  - LOAD=1 copies BIN/DP_IN into the pending registers and sets pending-valid. A later LOAD before the boundary overwrites the pending value.
  - At a frame boundary with pending-valid=1, pending is copied to the display registers and pending-valid is cleared.
  - LOAD coincident with a frame boundary: BIN/DP_IN go straight to the display registers for that frame; pending-valid ends 0.
  - The display never changes mid-frame.
- Decode (display nibble -> SEG, hex, active low):
  - 0:40 1:79 2:24 3:30 4:19 5:12 6:02 7:78
  - 8:00 9:10 A:08 b:03 C:46 d:21 E:06 F:0E
- Lit condition for digit DIG in its slot: EN=1, AND phase <= BRIGHT, AND the digit is not suppressed.
  - Lit: AN[DIG]=0, other AN bits 1, SEG = glyph, DP_OUT = ~DP_IN[DIG] (from the display register).
  - Not lit: AN all 1, SEG 7F, DP_OUT 1.
- Suppression (LZ_SUP=1): digit i>0 is suppressed when nibble i and all more-significant nibbles are 0.
  - Digit 0 is never suppressed.
  - Suppression ignores DP bits; a suppressed digit's DP is dark.
- Latency: SEG/DP_OUT/AN/FRAME are registered, valid 1 cycle after the counter state that selects them.
  - EN, BRIGHT and LZ_SUP changes take effect on the next cycle, with no frame alignment.
- AN only ever has at most one bit low. All transitions to a different digit pass through a cycle where AN is all 1 (ghosting guard): the last sub-counter cycle of each slot is forced dark.

Test Plan:
1. Reset: RST_N=0 for 3 cycles with LOAD=1 and BIN=16'hFFFF -> AN=4'hF, SEG=7'h7F, DP_OUT=1, FRAME=0. After release, the first displayed frame shows 0 (pending was cleared by reset).
2. Scan and decode (DIGITS=4, PHASE_LEN=2, slot = 32 cycles, BRIGHT=15, EN=1, LZ_SUP=0):
   - Stimulus: LOAD with BIN=16'h12AF, DP_IN=4'b0100.
   - From the next FRAME, AN steps 1110/1101/1011/0111 in 32-cycle slots.
   - SEG steps 0E/08/24/79; DP_OUT=0 only during digit 2.
   - Each slot's last cycle has AN=4'hF.
3. Leading zeros (LZ_SUP=1):
   - BIN=16'h0005 -> only AN[0] ever goes low, with SEG=12.
   - BIN=16'h0000 -> digit 0 shows 40.
   - BIN=16'h0305 -> digits 0..2 lit, with digit 1 = 40.
4. Brightness: BRIGHT=3 -> in each 32-cycle slot, AN[DIG]=0 for exactly 8 cycles (phases 0..3), then AN=4'hF for 24 cycles.
5. Frame sync:
   - LOAD BIN=16'h1111 in the middle of digit 1's slot -> the rest of the frame still shows the old value; the new value appears from the next FRAME.
   - LOAD BIN=16'h2222 in the FRAME cycle -> 2222 is shown in that same frame.
6. Blanking: drop EN=0 mid-slot -> AN=4'hF and SEG=7F from the next cycle, and FRAME keeps pulsing every 128 cycles. Raise EN=1 -> the digit selected by the still-running scan lights on the next cycle.

Source files
------------

// File: rtl/seg7_mux_drv_if.sv
// Pin bundle between user logic and the multiplexed 7-segment driver.
// The master side owns the value/control inputs; the slave side (the
// driver) owns the segment, anode and frame outputs. DIGITS must match
// the driver instance it is connected to.
interface seg7_mux_drv_if #(
  parameter int DIGITS = 4
);

  // Control and value inputs to the driver.
  logic                  EN;
  logic                  LZ_SUP;
  logic [3:0]            BRIGHT;
  logic                  LOAD;
  logic [4*DIGITS-1:0]   BIN;
  logic [DIGITS-1:0]     DP_IN;

  // Pin-side outputs (all active low except FRAME).
  logic [6:0]            SEG;
  logic                  DP_OUT;
  logic [DIGITS-1:0]     AN;
  logic                  FRAME;

  modport master (
    output EN, LZ_SUP, BRIGHT, LOAD, BIN, DP_IN,
    input  SEG, DP_OUT, AN, FRAME
  );

  modport slave (
    input  EN, LZ_SUP, BRIGHT, LOAD, BIN, DP_IN,
    output SEG, DP_OUT, AN, FRAME
  );

endinterface

// File: rtl/seg7_mux_drv.sv
// Multiplexed common-anode 7-segment driver for DIGITS digits.
// Each digit owns a slot of 16 brightness phases of PHASE_LEN cycles each.
// Values are double-buffered: LOAD fills a pending buffer, which is moved
// into the display buffer only at the frame wrap, so a frame never tears.
// All pin outputs are registered one cycle behind the counter state.
module seg7_mux_drv #(
  parameter int DIGITS    = 4,
  parameter int PHASE_LEN = 3125
) (
  input logic           CLK,
  input logic           RST_N,
  seg7_mux_drv_if.slave bus
);

  localparam int SUB_W = (PHASE_LEN > 1) ? $clog2(PHASE_LEN) : 1;
  localparam int DIG_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  localparam logic [SUB_W-1:0] SUB_LAST = SUB_W'(PHASE_LEN - 1);
  localparam logic [DIG_W-1:0] DIG_LAST = DIG_W'(DIGITS - 1);

  // Scan counters.
  logic [SUB_W-1:0]      sub_cnt;
  logic [3:0]            phase;
  logic [DIG_W-1:0]      dig;

  logic                  sub_wrap;
  logic                  phase_wrap;
  logic                  frame_wrap;

  // Double-buffered digit values.
  logic [4*DIGITS-1:0]   pend_bin;
  logic [DIGITS-1:0]     pend_dp;
  logic                  pend_valid;
  logic [4*DIGITS-1:0]   disp_bin;
  logic [DIGITS-1:0]     disp_dp;

  // Per-cycle selection results feeding the output registers.
  logic [3:0]            cur_nib;
  logic                  cur_dp;
  logic [DIGITS-1:0]     supp;
  logic                  zero_run;
  logic                  ghost;
  logic                  lit;
  logic [DIGITS-1:0]     an_next;
  logic                  frame_start;

  function automatic logic [6:0] hex_glyph(input logic [3:0] nib);
    logic [6:0] g;
    case (nib)
      4'h0:    g = 7'h40;
      4'h1:    g = 7'h79;
      4'h2:    g = 7'h24;
      4'h3:    g = 7'h30;
      4'h4:    g = 7'h19;
      4'h5:    g = 7'h12;
      4'h6:    g = 7'h02;
      4'h7:    g = 7'h78;
      4'h8:    g = 7'h00;
      4'h9:    g = 7'h10;
      4'hA:    g = 7'h08;
      4'hB:    g = 7'h03;
      4'hC:    g = 7'h46;
      4'hD:    g = 7'h21;
      4'hE:    g = 7'h06;
      default: g = 7'h0E;
    endcase
    return g;
  endfunction

  assign sub_wrap    = (sub_cnt == SUB_LAST);
  assign phase_wrap  = sub_wrap && (phase == 4'hF);
  assign frame_wrap  = phase_wrap && (dig == DIG_LAST);
  assign frame_start = (dig == '0) && (phase == 4'h0) && (sub_cnt == '0);

  // Free-running scan: sub-counter -> brightness phase -> digit index.
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      sub_cnt <= '0;
      phase   <= '0;
      dig     <= '0;
    end else begin
      sub_cnt <= sub_wrap ? '0 : sub_cnt + 1'b1;
      if (sub_wrap) begin
        phase <= phase + 4'h1;
      end
      if (phase_wrap) begin
        dig <= (dig == DIG_LAST) ? '0 : dig + 1'b1;
      end
    end
  end

  // Pending/display buffering; a LOAD landing on the wrap cycle bypasses
  // the pending buffer so it is shown in the frame that is starting.
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      pend_bin   <= '0;
      pend_dp    <= '0;
      pend_valid <= 1'b0;
      disp_bin   <= '0;
      disp_dp    <= '0;
    end else if (frame_wrap) begin
      if (bus.LOAD) begin
        disp_bin <= bus.BIN;
        disp_dp  <= bus.DP_IN;
      end else if (pend_valid) begin
        disp_bin <= pend_bin;
        disp_dp  <= pend_dp;
      end
      pend_valid <= 1'b0;
    end else if (bus.LOAD) begin
      pend_bin   <= bus.BIN;
      pend_dp    <= bus.DP_IN;
      pend_valid <= 1'b1;
    end
  end

  // Leading-zero map: walk from the most significant digit down, a digit is
  // blank while every nibble from it upward is zero; digit 0 always shows.
  always_comb begin
    supp     = '0;
    zero_run = 1'b1;
    for (int unsigned k = 0; k < DIGITS; k++) begin
      zero_run = zero_run && (disp_bin[(DIGITS-1-k)*4 +: 4] == 4'h0);
      supp[DIGITS-1-k] = bus.LZ_SUP && (k != DIGITS-1) && zero_run;
    end
  end

  // Lit decision and anode pattern for the digit currently being scanned;
  // the last sub-cycle of every slot is dark so anodes never overlap.
  always_comb begin
    cur_nib = disp_bin[int'(dig)*4 +: 4];
    cur_dp  = disp_dp[dig];
    ghost   = (phase == 4'hF) && sub_wrap;
    lit     = bus.EN && (phase <= bus.BRIGHT) && !supp[dig] && !ghost;
    an_next = '1;
    for (int unsigned i = 0; i < DIGITS; i++) begin
      an_next[i] = !(lit && (dig == DIG_W'(i)));
    end
  end

  // Registered pin outputs.
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      bus.AN     <= '1;
      bus.SEG    <= 7'h7F;
      bus.DP_OUT <= 1'b1;
      bus.FRAME  <= 1'b0;
    end else begin
      bus.AN     <= an_next;
      bus.SEG    <= lit ? hex_glyph(cur_nib) : 7'h7F;
      bus.DP_OUT <= lit ? ~cur_dp : 1'b1;
      bus.FRAME  <= frame_start;
    end
  end

endmodule

// File: tb/tb_seg7_mux_drv.sv
// Scoreboard bench for seg7_mux_drv (DIGITS=4, PHASE_LEN=2: 32-cycle slot,
// 128-cycle frame). A cycle-level reference model derives each expected
// pin state from elapsed time since reset and frame-level buffering, and
// queues it; a monitor pops and compares one entry per cycle.
module tb_seg7_mux_drv;

  localparam int DIGITS    = 4;
  localparam int PHASE_LEN = 2;
  localparam int SLOT      = 16 * PHASE_LEN;
  localparam int FRAME_LEN = DIGITS * SLOT;

  typedef struct packed {
    logic [DIGITS-1:0] an;
    logic [6:0]        seg;
    logic              dp;
    logic              frame;
  } exp_t;

  logic CLK = 1'b0;
  logic RST_N;

  always #5 CLK = ~CLK;

  seg7_mux_drv_if #(.DIGITS(DIGITS)) bus ();

  seg7_mux_drv #(
    .DIGITS   (DIGITS),
    .PHASE_LEN(PHASE_LEN)
  ) dut (
    .CLK  (CLK),
    .RST_N(RST_N),
    .bus  (bus)
  );

  exp_t q[$];
  int   checks = 0;
  int   errors = 0;

  logic [6:0] glyph [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                             7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

  // Reference model state.
  int unsigned         cyc = 0;
  logic [4*DIGITS-1:0] m_disp = '0;
  logic [4*DIGITS-1:0] m_pend = '0;
  logic [DIGITS-1:0]   m_ddp = '0;
  logic [DIGITS-1:0]   m_pdp = '0;
  bit                  m_pv = 1'b0;

  // Reference model: runs on every rising edge with the inputs the DUT samples.
  initial begin
    exp_t        e;
    int unsigned pos, d, o, ph;
    logic [3:0]  nib;
    bit          l;
    forever begin
      @(posedge CLK);
      e.an = '1; e.seg = 7'h7F; e.dp = 1'b1; e.frame = 1'b0;
      if (RST_N !== 1'b1) begin
        cyc = 0; m_disp = '0; m_pend = '0; m_ddp = '0; m_pdp = '0; m_pv = 1'b0;
      end else begin
        pos = cyc % FRAME_LEN;
        d   = pos / SLOT;
        o   = pos % SLOT;
        ph  = o / PHASE_LEN;
        nib = 4'(m_disp >> (4 * d));
        l   = bus.EN && (ph <= 32'(bus.BRIGHT)) && (o != SLOT - 1) &&
              !(bus.LZ_SUP && d > 0 && (m_disp >> (4 * d)) == 0);
        e.frame = (pos == 0);
        if (l) begin
          e.an[d] = 1'b0;
          e.seg   = glyph[nib];
          e.dp    = ~m_ddp[d];
        end
        if (pos == FRAME_LEN - 1) begin
          if (bus.LOAD) begin
            m_disp = bus.BIN; m_ddp = bus.DP_IN;
          end else if (m_pv) begin
            m_disp = m_pend; m_ddp = m_pdp;
          end
          m_pv = 1'b0;
        end else if (bus.LOAD) begin
          m_pend = bus.BIN; m_pdp = bus.DP_IN; m_pv = 1'b1;
        end
        cyc++;
      end
      q.push_back(e);
    end
  end

  // Monitor: one expected entry per cycle, sampled 1 time unit after the edge.
  initial begin
    exp_t e;
    forever begin
      @(posedge CLK);
      #1;
      checks++;
      if ($countones(~bus.AN) > 1) begin
        errors++;
        $display("FAIL an_onehot t=%0t AN=%b required at most one low bit", $time, bus.AN);
      end
      checks++;
      if (q.size() == 0) begin
        errors++;
        $display("FAIL queue_empty t=%0t got output with no expected entry", $time);
      end else begin
        e = q.pop_front();
        if ({bus.AN, bus.SEG, bus.DP_OUT, bus.FRAME} !== e) begin
          errors++;
          $display("FAIL pins t=%0t got AN=%b SEG=%h DP=%b FRAME=%b required AN=%b SEG=%h DP=%b FRAME=%b",
                   $time, bus.AN, bus.SEG, bus.DP_OUT, bus.FRAME, e.an, e.seg, e.dp, e.frame);
        end
      end
    end
  end

  task automatic step(input int n);
    repeat (n) @(negedge CLK);
  endtask

  task automatic load(input logic [4*DIGITS-1:0] b, input logic [DIGITS-1:0] dp);
    bus.LOAD = 1'b1; bus.BIN = b; bus.DP_IN = dp;
    @(negedge CLK);
    bus.LOAD = 1'b0;
  endtask

  // Advance until the next sampling edge falls at the given frame position.
  task automatic go_to_pos(input int unsigned target);
    int guard = 0;
    while ((cyc % FRAME_LEN) != target && guard < 2 * FRAME_LEN) begin
      @(negedge CLK);
      guard++;
    end
    checks++;
    if ((cyc % FRAME_LEN) != target) begin
      errors++;
      $display("FAIL go_to_pos got %0d required %0d", cyc % FRAME_LEN, target);
    end
  endtask

  initial begin
    logic [4*DIGITS-1:0] b;
    // Reset with a LOAD held active; it must not survive reset.
    RST_N = 1'b0;
    bus.EN = 1'b1; bus.LZ_SUP = 1'b0; bus.BRIGHT = 4'hF;
    bus.LOAD = 1'b1; bus.BIN = 16'hFFFF; bus.DP_IN = 4'hF;
    step(3);
    RST_N = 1'b1; bus.LOAD = 1'b0;
    step(FRAME_LEN + 10);

    // Scan and decode.
    load(16'h12AF, 4'b0100);
    step(2 * FRAME_LEN);

    // Leading-zero suppression.
    bus.LZ_SUP = 1'b1;
    load(16'h0005, 4'b0000); step(2 * FRAME_LEN);
    load(16'h0000, 4'b0010); step(2 * FRAME_LEN);
    load(16'h0305, 4'b1000); step(2 * FRAME_LEN);

    // Brightness.
    bus.BRIGHT = 4'h3;
    step(FRAME_LEN);
    bus.BRIGHT = 4'h0;
    step(FRAME_LEN);
    bus.BRIGHT = 4'hF; bus.LZ_SUP = 1'b0;

    // Frame sync: mid-frame load waits, overwrite of pending, load on the wrap cycle.
    go_to_pos(SLOT + 10);
    load(16'h1111, 4'b0001);
    step(FRAME_LEN + 20);
    load(16'h5555, 4'b0000);
    load(16'h6789, 4'b0011);
    step(FRAME_LEN);
    go_to_pos(FRAME_LEN - 1);
    load(16'h2222, 4'b1111);
    step(FRAME_LEN);

    // Blanking mid-slot, frames keep running, then resume.
    go_to_pos(2 * SLOT + 7);
    bus.EN = 1'b0;
    step(3 * FRAME_LEN);
    bus.EN = 1'b1;
    step(FRAME_LEN);

    // Randomised traffic with a mid-frame reset.
    for (int i = 0; i < 3000; i++) begin
      if (i % 64 == 0) begin
        bus.BRIGHT = 4'($urandom_range(0, 15));
        bus.LZ_SUP = 1'($urandom_range(0, 1));
      end
      bus.EN = ($urandom_range(0, 9) != 0);
      for (int k = 0; k < DIGITS; k++) begin
        b[k*4 +: 4] = ($urandom_range(0, 1) != 0) ? 4'h0 : 4'($urandom_range(0, 15));
      end
      bus.BIN   = b;
      bus.DP_IN = 4'($urandom_range(0, 15));
      bus.LOAD  = ($urandom_range(0, 15) == 0);
      RST_N     = !(i >= 1500 && i < 1502);
      @(negedge CLK);
    end
    bus.LOAD = 1'b0; RST_N = 1'b1;
    step(4);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
